// File: rtl/qsp_elevator.sv
// qspa_pkg: core-wide constants shared by QSP datapath blocks.
package qspa_pkg;
    parameter int DATA_WIDTH = 16;
endpackage

// qsp_elevator: hardware loop-counter unit fed by LCSET writeback.
// Each LCSET pushes {iteration count, loop-start PC} onto a nesting stack;
// each loop-end event either decrements the innermost count and redirects
// fetch to the loop start, or pops the finished loop and falls through.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   lc_wr_valid     LCSET commits this cycle (lc_wr_data = count, lc_wr_pc = its PC)
//   loop_end_valid  loop-end instruction commits this cycle
//   flush           discard all stack entries
//   err_clr         clear sticky error flags
//   redirect_valid  registered one-cycle pulse, fetch jumps to redirect_pc
//   redirect_pc     loop start address (holds last value between pulses)
//   lc_top          remaining count of innermost loop (0 when empty)
//   lc_depth        number of active loops; lc_empty / lc_full decode it
//   ovf_err         sticky: push while full
//   unf_err         sticky: loop end while empty
//
// Handshake: every *_valid input is a single-cycle qualifier with no ready;
// the unit accepts every event in the cycle it is presented.
module qsp_elevator #(
    parameter int DATA_WIDTH = qspa_pkg::DATA_WIDTH,
    parameter int PC_WIDTH   = 16,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lc_wr_valid,
    input  logic [DATA_WIDTH-1:0]      lc_wr_data,
    input  logic [PC_WIDTH-1:0]        lc_wr_pc,
    input  logic                       loop_end_valid,
    input  logic                       flush,
    input  logic                       err_clr,
    output logic                       redirect_valid,
    output logic [PC_WIDTH-1:0]        redirect_pc,
    output logic [DATA_WIDTH-1:0]      lc_top,
    output logic [$clog2(DEPTH):0]     lc_depth,
    output logic                       lc_empty,
    output logic                       lc_full,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int DW = IW + 1;

    logic [DATA_WIDTH-1:0] r_cnt [DEPTH];
    logic [PC_WIDTH-1:0]   r_spc [DEPTH];
    logic [DW-1:0]         r_depth;
    logic                  r_redirect_valid;
    logic [PC_WIDTH-1:0]   r_redirect_pc;
    logic                  r_ovf_err;
    logic                  r_unf_err;

    logic                  w_empty;
    logic                  w_full;
    logic [IW-1:0]         w_top_idx;
    logic [DATA_WIDTH-1:0] w_top_cnt;
    logic                  w_dec;
    logic                  w_pop;
    logic                  w_unf;
    logic [DW-1:0]         w_depth_mid;
    logic                  w_push;
    logic                  w_ovf;
    logic [IW-1:0]         w_push_idx;
    logic [DATA_WIDTH-1:0] w_push_cnt;
    logic [PC_WIDTH-1:0]   w_push_pc;
    logic [DW-1:0]         w_depth_nxt;

    assign w_empty   = (r_depth == '0);
    assign w_full    = (r_depth == DW'(DEPTH));
    // Wraps to all-ones when empty; every use is gated by !w_empty.
    assign w_top_idx = IW'(r_depth - DW'(1));
    assign w_top_cnt = r_cnt[w_top_idx];

    // Loop end acts first on the pre-push top; the push then sees the
    // post-pop depth, so a pop while full frees a slot for the same cycle.
    always_comb begin
        w_dec       = 1'b0;
        w_pop       = 1'b0;
        w_unf       = 1'b0;
        w_depth_mid = r_depth;
        if (loop_end_valid) begin
            if (w_empty) begin
                w_unf = 1'b1;
            end else if (w_top_cnt > DATA_WIDTH'(1)) begin
                w_dec = 1'b1;
            end else begin
                w_pop       = 1'b1;
                w_depth_mid = r_depth - DW'(1);
            end
        end
        w_push      = lc_wr_valid && (w_depth_mid != DW'(DEPTH));
        w_ovf       = lc_wr_valid && (w_depth_mid == DW'(DEPTH));
        w_push_idx  = w_depth_mid[IW-1:0];
        // A zero count runs the body once, same as a count of one.
        w_push_cnt  = (lc_wr_data == '0) ? DATA_WIDTH'(1) : lc_wr_data;
        w_push_pc   = lc_wr_pc + PC_WIDTH'(1);
        w_depth_nxt = w_push ? (w_depth_mid + DW'(1)) : w_depth_mid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= '0;
                r_spc[i] <= '0;
            end
            r_depth          <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_ovf_err        <= 1'b0;
            r_unf_err        <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            if (flush) begin
                // Flush cancels any same-cycle push or loop end.
                r_depth <= '0;
            end else begin
                if (w_dec) begin
                    r_cnt[w_top_idx] <= w_top_cnt - DATA_WIDTH'(1);
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= r_spc[w_top_idx];
                end
                if (w_push) begin
                    r_cnt[w_push_idx] <= w_push_cnt;
                    r_spc[w_push_idx] <= w_push_pc;
                end
                r_depth <= w_depth_nxt;
            end
            // A new error in the same cycle as err_clr wins.
            r_ovf_err <= (r_ovf_err && !err_clr) || (w_ovf && !flush);
            r_unf_err <= (r_unf_err && !err_clr) || (w_unf && !flush);
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign lc_top         = w_empty ? '0 : w_top_cnt;
    assign lc_depth       = r_depth;
    assign lc_empty       = w_empty;
    assign lc_full        = w_full;
    assign ovf_err        = r_ovf_err;
    assign unf_err        = r_unf_err;

endmodule

// File: tb/tb_qsp_elevator.sv
module tb_qsp_elevator;

    localparam int DW    = qspa_pkg::DATA_WIDTH;
    localparam int PW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lc_wr_valid = 1'b0;
    logic [DW-1:0] lc_wr_data = '0;
    logic [PW-1:0] lc_wr_pc = '0;
    logic          loop_end_valid = 1'b0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic [DW-1:0] lc_top;
    logic [2:0]    lc_depth;
    logic          lc_empty;
    logic          lc_full;
    logic          ovf_err;
    logic          unf_err;

    qsp_elevator #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .lc_wr_valid(lc_wr_valid), .lc_wr_data(lc_wr_data), .lc_wr_pc(lc_wr_pc),
        .loop_end_valid(loop_end_valid), .flush(flush), .err_clr(err_clr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .lc_top(lc_top), .lc_depth(lc_depth), .lc_empty(lc_empty), .lc_full(lc_full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the loop stack as two queues, innermost at the back.
    logic [DW-1:0] m_cnt_q[$];
    logic [PW-1:0] m_pc_q[$];
    logic          m_rv  = 1'b0;
    logic [PW-1:0] m_rpc = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    always @(posedge clk) begin
        logic new_ovf, new_unf;
        logic [PW-1:0] npc;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (rst) begin
            m_cnt_q.delete();
            m_pc_q.delete();
            m_rv = 1'b0; m_rpc = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            m_rv = 1'b0;
            if (flush) begin
                m_cnt_q.delete();
                m_pc_q.delete();
            end else begin
                if (loop_end_valid) begin
                    if (m_cnt_q.size() == 0) new_unf = 1'b1;
                    else if (m_cnt_q[$] > 1) begin
                        m_cnt_q[$] = m_cnt_q[$] - 1'b1;
                        m_rv  = 1'b1;
                        m_rpc = m_pc_q[$];
                    end else begin
                        void'(m_cnt_q.pop_back());
                        void'(m_pc_q.pop_back());
                    end
                end
                if (lc_wr_valid) begin
                    if (m_cnt_q.size() == DEPTH) new_ovf = 1'b1;
                    else begin
                        npc = lc_wr_pc + 16'd1;
                        m_cnt_q.push_back(lc_wr_data == 0 ? DW'(1) : lc_wr_data);
                        m_pc_q.push_back(npc);
                    end
                end
            end
            m_ovf = new_ovf | (m_ovf & ~err_clr);
            m_unf = new_unf | (m_unf & ~err_clr);
        end
    end

    // scoreboard: compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
            chk("redirect_pc",    32'(redirect_pc),    32'(m_rpc));
            chk("lc_top",         32'(lc_top),   m_cnt_q.size() == 0 ? 32'd0 : 32'(m_cnt_q[$]));
            chk("lc_depth",       32'(lc_depth), 32'(m_cnt_q.size()));
            chk("lc_empty",       32'(lc_empty), 32'(m_cnt_q.size() == 0));
            chk("lc_full",        32'(lc_full),  32'(m_cnt_q.size() == DEPTH));
            chk("ovf_err",        32'(ovf_err),  32'(m_ovf));
            chk("unf_err",        32'(unf_err),  32'(m_unf));
        end
    end

    // driver tasks: inputs applied on negedge, effect visible at the next negedge
    task automatic step(input bit wr, input logic [DW-1:0] d, input logic [PW-1:0] pc,
                        input bit le, input bit fl, input bit ec, input bit rs);
        lc_wr_valid = wr; lc_wr_data = d; lc_wr_pc = pc;
        loop_end_valid = le; flush = fl; err_clr = ec; rst = rs;
        @(negedge clk);
        lc_wr_valid = 1'b0; loop_end_valid = 1'b0; flush = 1'b0; err_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic idle();          step(0, '0, '0, 0, 0, 0, 0); endtask
    task automatic push(input logic [DW-1:0] d, input logic [PW-1:0] pc); step(1, d, pc, 0, 0, 0, 0); endtask
    task automatic lend();          step(0, '0, '0, 1, 0, 0, 0); endtask

    initial begin
        @(negedge clk);
        step(0, '0, '0, 0, 0, 0, 1);
        chk_en = 1'b1;
        chk("lit reset depth", 32'(lc_depth), 32'd0);
        chk("lit reset empty", 32'(lc_empty), 32'd1);
        chk("lit reset top",   32'(lc_top),   32'd0);

        // single loop of 3
        push(3, 16'h0010); idle();
        lend(); chk("lit l1 rv", 32'(redirect_valid), 32'd1);
        chk("lit l1 pc", 32'(redirect_pc), 32'h11); chk("lit l1 top", 32'(lc_top), 32'd2);
        idle(); chk("lit l1 pulse", 32'(redirect_valid), 32'd0);
        lend(); chk("lit l2 top", 32'(lc_top), 32'd1);
        idle();
        lend(); chk("lit l3 rv", 32'(redirect_valid), 32'd0); chk("lit l3 empty", 32'(lc_empty), 32'd1);

        // nested
        push(2, 16'h0020); push(2, 16'h0030);
        chk("lit n depth", 32'(lc_depth), 32'd2);
        lend(); chk("lit n pc1", 32'(redirect_pc), 32'h31); chk("lit n d1", 32'(lc_depth), 32'd2);
        lend(); chk("lit n d2", 32'(lc_depth), 32'd1);
        lend(); chk("lit n pc3", 32'(redirect_pc), 32'h21);
        lend(); chk("lit n d4", 32'(lc_depth), 32'd0);

        // overflow, then pop+push at full
        for (int i = 0; i < 4; i++) push(1, 16'(i));
        chk("lit full", 32'(lc_full), 32'd1);
        push(9, 16'h0099);
        chk("lit ovf", 32'(ovf_err), 32'd1); chk("lit ovf top", 32'(lc_top), 32'd1);
        step(0, '0, '0, 0, 0, 1, 0); chk("lit ovf clr", 32'(ovf_err), 32'd0);
        step(1, 5, 16'h00FF, 1, 0, 0, 0);
        chk("lit sim depth", 32'(lc_depth), 32'd4); chk("lit sim top", 32'(lc_top), 32'd5);
        chk("lit sim ovf", 32'(ovf_err), 32'd0);

        // pc wrap
        step(0, '0, '0, 0, 1, 0, 0);
        push(2, 16'hFFFF); lend();
        chk("lit wrap rv", 32'(redirect_valid), 32'd1); chk("lit wrap pc", 32'(redirect_pc), 32'd0);

        // underflow, zero count
        step(0, '0, '0, 0, 1, 0, 0);
        lend(); chk("lit unf", 32'(unf_err), 32'd1); chk("lit unf rv", 32'(redirect_valid), 32'd0);
        push(0, 16'h0050); lend();
        chk("lit zero rv", 32'(redirect_valid), 32'd0); chk("lit zero empty", 32'(lc_empty), 32'd1);

        // reset mid-loop
        push(7, 16'h0040); lend();
        step(0, '0, '0, 0, 0, 0, 1);
        chk("lit rst depth", 32'(lc_depth), 32'd0); chk("lit rst rv", 32'(redirect_valid), 32'd0);
        chk("lit rst unf", 32'(unf_err), 32'd0);

        // flush mid-loop keeps sticky error
        lend(); push(7, 16'h0040); lend();
        step(0, '0, '0, 0, 1, 0, 0);
        chk("lit fl depth", 32'(lc_depth), 32'd0); chk("lit fl rv", 32'(redirect_valid), 32'd0);
        chk("lit fl unf", 32'(unf_err), 32'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit wr, le, fl, ec, rs;
            wr = ($urandom_range(0, 99) < 35);
            le = ($urandom_range(0, 99) < 45);
            ec = ($urandom_range(0, 99) < 5);
            rs = ($urandom_range(0, 999) < 5);
            fl = !wr && !le && ($urandom_range(0, 99) < 4);
            step(wr, DW'($urandom_range(0, 4)), PW'($urandom), le, fl, ec, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
